// File: rtl/capture_cfg_pkg.sv
// Shared types and default constants for the capture configuration scheduler.
package capture_cfg_pkg;

  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_SETTLE_CYCLES  = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  localparam int unsigned TMR_W     = 16;
  localparam int unsigned COMMIT_W  = 16;
  localparam int unsigned TO_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_BND = 2'd2
  } state_e;

endpackage

// File: rtl/capture_cfg_timer.sv
// Clear/enable up-counter with a terminal-count compare; shared by the settle
// and boundary-timeout phases of the scheduler.
module capture_cfg_timer
  import capture_cfg_pkg::*;
(
  input  logic             user_clk,
  input  logic             user_rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [TMR_W-1:0] term,
  output logic             tc_c
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c = (cnt_q == term);

endmodule

// File: rtl/capture_cfg_scheduler.sv
// Debounces a software configuration word and applies it to the capture
// datapath only on a frame boundary, or after a timeout if none arrives.
module capture_cfg_scheduler
  import capture_cfg_pkg::*;
#(
  parameter int unsigned          DATA_W         = DEF_DATA_W,
  parameter int unsigned          SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [DATA_W-1:0]    RESET_CFG      = '0
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [DATA_W-1:0]   sw_cfg,
  input  logic                frame_boundary,
  output logic [DATA_W-1:0]   cfg_active,
  output logic                cfg_update,
  output logic                busy,
  output logic [15:0]         commit_count,
  output logic [7:0]          timeout_count
);

  localparam logic [TMR_W-1:0] SETTLE_TERM  = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_TERM = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     cand_q, cand_d;
  logic [DATA_W-1:0]     cfg_active_q, cfg_active_d;
  logic                  cfg_update_q, cfg_update_d;
  logic                  busy_q, busy_d;
  logic [COMMIT_W-1:0]   commit_count_q, commit_count_d;
  logic [TO_CNT_W-1:0]   timeout_count_q, timeout_count_d;

  logic                  tmr_clr;
  logic                  tmr_en;
  logic [TMR_W-1:0]      tmr_term;
  logic                  tmr_tc_c;

  // One counter serves both phases; only the terminal value changes.
  assign tmr_term = (state_q == WAIT_BND) ? TIMEOUT_TERM : SETTLE_TERM;

  capture_cfg_timer u_timer (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .clr        (tmr_clr),
    .en         (tmr_en),
    .term       (tmr_term),
    .tc_c       (tmr_tc_c)
  );

  always_comb begin
    state_d         = state_q;
    cand_d          = cand_q;
    cfg_active_d    = cfg_active_q;
    cfg_update_d    = 1'b0;
    commit_count_d  = commit_count_q;
    timeout_count_d = timeout_count_q;
    tmr_clr         = 1'b0;
    tmr_en          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sw_cfg != cfg_active_q) begin
          cand_d  = sw_cfg;
          tmr_clr = 1'b1;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (sw_cfg == cfg_active_q) begin
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else if (sw_cfg != cand_q) begin
          cand_d  = sw_cfg;
          tmr_clr = 1'b1;
        end else if (tmr_tc_c) begin
          tmr_clr = 1'b1;
          state_d = WAIT_BND;
        end else begin
          tmr_en = 1'b1;
        end
      end

      WAIT_BND: begin
        // A changing word outranks both commit causes.
        if (sw_cfg != cand_q) begin
          cand_d  = sw_cfg;
          tmr_clr = 1'b1;
          state_d = SETTLE;
        end else if (frame_boundary || tmr_tc_c) begin
          cfg_active_d   = cand_q;
          cfg_update_d   = 1'b1;
          commit_count_d = commit_count_q + COMMIT_W'(1);
          if (!frame_boundary && (timeout_count_q != '1)) begin
            timeout_count_d = timeout_count_q + TO_CNT_W'(1);
          end
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        tmr_clr = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q         <= IDLE;
      cand_q          <= RESET_CFG;
      cfg_active_q    <= RESET_CFG;
      cfg_update_q    <= 1'b0;
      busy_q          <= 1'b0;
      commit_count_q  <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cand_q          <= cand_d;
      cfg_active_q    <= cfg_active_d;
      cfg_update_q    <= cfg_update_d;
      busy_q          <= busy_d;
      commit_count_q  <= commit_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign cfg_active    = cfg_active_q;
  assign cfg_update    = cfg_update_q;
  assign busy          = busy_q;
  assign commit_count  = commit_count_q;
  assign timeout_count = timeout_count_q;

endmodule
